// File: rtl/vga_text_pkg.sv
// Shared constants for the text banner: glyph codes, the 32-glyph 8x8 font,
// the power-on banner text and the window-width helper.
package vga_text_pkg;

   localparam logic [4:0] GLYPH_SPACE = 5'd0;
   localparam logic [4:0] GLYPH_0     = 5'd1;
   localparam logic [4:0] GLYPH_3     = 5'd4;
   localparam logic [4:0] GLYPH_DOT   = 5'd11;
   localparam logic [4:0] GLYPH_A     = 5'd12;
   localparam logic [4:0] GLYPH_H     = 5'd19;
   localparam logic [4:0] GLYPH_L     = 5'd23;
   localparam logic [4:0] GLYPH_P     = 5'd27;
   localparam logic [4:0] GLYPH_S     = 5'd30;

   // Row 0 is the top of the glyph; bit 7 of each row is the leftmost pixel.
   localparam logic [7:0] FONT_ROWS [32][8] = '{
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
      '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
      '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
      '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
      '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
      '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
      '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
      '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
      '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
      '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00},
      '{8'h00, 8'h00, 8'h3C, 8'h06, 8'h3E, 8'h66, 8'h3E, 8'h00},
      '{8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h00},
      '{8'h00, 8'h00, 8'h3C, 8'h60, 8'h60, 8'h60, 8'h3C, 8'h00},
      '{8'h06, 8'h06, 8'h3E, 8'h66, 8'h66, 8'h66, 8'h3E, 8'h00},
      '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h7E, 8'h60, 8'h3C, 8'h00},
      '{8'h1C, 8'h30, 8'h7C, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00},
      '{8'h00, 8'h00, 8'h3E, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h3C},
      '{8'h80, 8'h80, 8'hB8, 8'hC4, 8'h84, 8'h84, 8'h84, 8'h00},
      '{8'h18, 8'h00, 8'h38, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},
      '{8'h06, 8'h00, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
      '{8'h60, 8'h60, 8'h66, 8'h6C, 8'h78, 8'h6C, 8'h66, 8'h00},
      '{8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},
      '{8'h00, 8'h00, 8'h66, 8'h7F, 8'h7F, 8'h6B, 8'h63, 8'h00},
      '{8'h00, 8'h00, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h00},
      '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
      '{8'h00, 8'h00, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h60, 8'h60},
      '{8'h00, 8'h00, 8'h3E, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h06},
      '{8'h00, 8'h00, 8'h7C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h00},
      '{8'h00, 8'h00, 8'h3E, 8'h60, 8'h3C, 8'h06, 8'h7C, 8'h00},
      '{8'h30, 8'h30, 8'h7C, 8'h30, 8'h30, 8'h30, 8'h1C, 8'h00}
   };

   // "hs3.pl" in cells 2..7; sized for the largest line so any NUM_CHARS can index it.
   localparam logic [4:0] DEFAULT_TEXT [32] = '{
      2: GLYPH_H, 3: GLYPH_S, 4: GLYPH_3, 5: GLYPH_DOT, 6: GLYPH_P, 7: GLYPH_L,
      default: GLYPH_SPACE
   };

   function automatic int win_width(input int num_chars, input int scale_log2);
      return num_chars * (8 << scale_log2);
   endfunction

endpackage

// File: rtl/vga_text_banner_font_rom.sv
// Font ROM for the banner: glyph code and row are registered, row bits come out one cycle later.
module banner_font_rom
   import vga_text_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_code,
   input  logic [2:0] i_row,
   output logic [7:0] o_data
);

   logic [4:0] r_code;
   logic [2:0] r_row;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_code <= '0;
         r_row  <= '0;
      end else begin
         r_code <= i_code;
         r_row  <= i_row;
      end
   end

   assign o_data = FONT_ROWS[r_code][r_row];

endmodule

// File: rtl/vga_text_banner.sv
// Scalable, scrollable text banner overlay with a 3-cycle pixel pipeline.
// Define BANNER_BLINK_EN to add the blink input and the per-frame blink counter.
module vga_text_banner
   import vga_text_pkg::*;
#(
   parameter int NUM_CHARS  = 16,
   parameter int SCALE_LOG2 = 0,
   parameter int ORIGIN_X   = 0,
   parameter int ORIGIN_Y   = 100,
   parameter int SCROLL_DIV = 2
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [9:0]                   pix_x,
   input  logic [9:0]                   pix_y,
   input  logic                         video_active,
   input  logic                         hsync_in,
   input  logic                         vsync_in,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_CHARS)-1:0] wr_addr,
   input  logic [4:0]                   wr_char,
   input  logic                         scroll_en,
   input  logic [5:0]                   fg_color,
   input  logic [5:0]                   bg_color,
`ifdef BANNER_BLINK_EN
   input  logic                         blink,
`endif
   output logic [5:0]                   rgb,
   output logic                         hsync_out,
   output logic                         vsync_out
);

   localparam int CELL = 8 << SCALE_LOG2;
   localparam int W    = win_width(NUM_CHARS, SCALE_LOG2);
   localparam int LXW  = $clog2(W) + 1;
   localparam int LW   = LXW - 1;
   localparam int LYW  = 3 + SCALE_LOG2;
   localparam int CW   = $clog2(NUM_CHARS);

   localparam logic [11:0]    X_LO    = 12'(ORIGIN_X);
   localparam logic [11:0]    Y_LO    = 12'(ORIGIN_Y);
   localparam logic [11:0]    W12     = 12'(W);
   localparam logic [11:0]    H12     = 12'(CELL);
   localparam logic [LXW-1:0] W_L     = LXW'(W);
   localparam logic [LXW-1:0] OFF_MAX = LXW'(W - 1);
   localparam logic [3:0]     DIV_MAX = 4'(SCROLL_DIV - 1);

   logic                 r_vsPrev;
   logic [3:0]           r_div;
   logic [LXW-1:0]       r_offset;
   logic                 w_vsRise;
   logic                 w_hide;

   logic [12:0]          w_dx;
   logic [12:0]          w_dy;
   logic                 w_inWin;
   logic [LXW-1:0]       w_lxSum;
   logic [LW-1:0]        w_lx;

   logic                 r_inWin0, r_active0, r_hs0, r_vs0, r_hide0;
   logic [LW-1:0]        r_lx0;
   logic [LYW-1:0]       r_ly0;

   logic [4:0]           r_buf [NUM_CHARS];
   logic [CW-1:0]        w_cell;
   logic [4:0]           w_code;

   logic                 r_inWin1, r_active1, r_hs1, r_vs1, r_hide1;
   logic [2:0]           r_col1;
   logic [7:0]           w_romData;
   logic                 w_bit;

   assign w_vsRise = vsync_in & ~r_vsPrev;

   // Marquee: the divider counts enabled frames, the offset steps once per SCROLL_DIV of them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vsPrev <= 1'b0;
         r_div    <= '0;
         r_offset <= '0;
      end else begin
         r_vsPrev <= vsync_in;
         if (w_vsRise && scroll_en) begin
            if (r_div == DIV_MAX) begin
               r_div    <= '0;
               r_offset <= (r_offset == OFF_MAX) ? '0 : r_offset + 1'b1;
            end else begin
               r_div <= r_div + 1'b1;
            end
         end
      end
   end

`ifdef BANNER_BLINK_EN
   logic [5:0] r_frame;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame <= '0;
      end else if (w_vsRise) begin
         r_frame <= r_frame + 1'b1;
      end
   end

   assign w_hide = blink & r_frame[5];
`else
   assign w_hide = 1'b0;
`endif

   // A borrow out of the 13-bit subtract means the pixel lies left of / above the origin.
   assign w_dx    = {3'b000, pix_x} - {1'b0, X_LO};
   assign w_dy    = {3'b000, pix_y} - {1'b0, Y_LO};
   assign w_inWin = !w_dx[12] && (w_dx[11:0] < W12) && !w_dy[12] && (w_dy[11:0] < H12);
   assign w_lxSum = w_dx[LXW-1:0] + r_offset;
   assign w_lx    = LW'((w_lxSum >= W_L) ? (w_lxSum - W_L) : w_lxSum);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inWin0  <= 1'b0;
         r_active0 <= 1'b0;
         r_hs0     <= 1'b0;
         r_vs0     <= 1'b0;
         r_hide0   <= 1'b0;
         r_lx0     <= '0;
         r_ly0     <= '0;
      end else begin
         r_inWin0  <= w_inWin;
         r_active0 <= video_active;
         r_hs0     <= hsync_in;
         r_vs0     <= vsync_in;
         r_hide0   <= w_hide;
         r_lx0     <= w_lx;
         r_ly0     <= w_dy[LYW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CHARS; i++) begin
            r_buf[i] <= DEFAULT_TEXT[i];
         end
      end else if (wr_en) begin
         r_buf[wr_addr] <= wr_char;
      end
   end

   // The ROM's address register is the registered buffer read, so a same-edge write is not seen.
   assign w_cell = r_lx0[LW-1:3+SCALE_LOG2];
   assign w_code = r_buf[w_cell];

   banner_font_rom u_fontRom (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_code (w_code),
      .i_row  (r_ly0[SCALE_LOG2+2:SCALE_LOG2]),
      .o_data (w_romData)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inWin1  <= 1'b0;
         r_active1 <= 1'b0;
         r_hs1     <= 1'b0;
         r_vs1     <= 1'b0;
         r_hide1   <= 1'b0;
         r_col1    <= '0;
      end else begin
         r_inWin1  <= r_inWin0;
         r_active1 <= r_active0;
         r_hs1     <= r_hs0;
         r_vs1     <= r_vs0;
         r_hide1   <= r_hide0;
         r_col1    <= r_lx0[SCALE_LOG2+2:SCALE_LOG2];
      end
   end

   assign w_bit = w_romData[3'd7 - r_col1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb       <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         hsync_out <= r_hs1;
         vsync_out <= r_vs1;
         if (!r_active1) begin
            rgb <= '0;
         end else if (r_inWin1 && w_bit && !r_hide1) begin
            rgb <= fg_color;
         end else begin
            rgb <= bg_color;
         end
      end
   end

endmodule
